// File: rtl/mem_stage_rsp_if.sv
// EX/MEM/WB/ID handshake, payload and data-memory response signals for mem_stage_rsp.
// es_load_op is one-hot: [0]lb [1]lh [2]lw [3]lbu [4]lhu [5]ld [6]lwu.
interface mem_stage_rsp_if #(
  parameter int DATA_W = 32,
  parameter int SB_W   = 64
);
  logic                            ws_allowin;
  logic                            ms_allowin;
  logic                            es_to_ms_valid;
  logic                            es_req_sent;
  logic                            es_ex;
  logic [6:0]                      es_load_op;
  logic                            es_res_from_mem;
  logic                            es_gr_we;
  logic [4:0]                      es_dest;
  logic [DATA_W-1:0]               es_alu_result;
  logic [31:0]                     es_pc;
  logic [SB_W-1:0]                 es_sb;
  logic                            data_sram_data_ok;
  logic [DATA_W-1:0]               data_sram_rdata;
  logic                            ms_flush_pipe;
  logic                            ms_to_ws_valid;
  logic [SB_W+1+1+5+DATA_W+32-1:0] ms_to_ws_bus;
  logic [DATA_W+8-1:0]             ms_fwd_bus;
  logic                            ms_ex;

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_req_sent, es_ex, es_load_op,
           es_res_from_mem, es_gr_we, es_dest, es_alu_result, es_pc, es_sb,
           data_sram_data_ok, data_sram_rdata, ms_flush_pipe,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex
  );

  modport master (
    output ws_allowin, es_to_ms_valid, es_req_sent, es_ex, es_load_op,
           es_res_from_mem, es_gr_we, es_dest, es_alu_result, es_pc, es_sb,
           data_sram_data_ok, data_sram_rdata, ms_flush_pipe,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex
  );
endinterface

// File: rtl/mem_stage_rsp.sv
// MEM pipeline stage: waits on variable-latency load responses, buffers them under WB stall,
// drops responses owed to flushed loads, and aligns/extends load data for WB and ID forwarding.
module mem_stage_rsp #(
  parameter int DATA_W  = 32,
  parameter int SB_W    = 64,
  parameter int MAX_OUT = 2
) (
  input logic            clk,
  input logic            reset,
  mem_stage_rsp_if.slave ms
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  function automatic logic [DATA_W-1:0] load_align(input logic [6:0]        op,
                                                   input logic [DATA_W-1:0] word,
                                                   input logic [OFF_W-1:0]  off);
    logic [DATA_W-1:0] b_sh, h_sh, w_sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b_sh = word >> (8 * int'(off));
    h_sh = word >> (16 * (int'(off) >> 1));
    w_sh = word >> (32 * (int'(off) >> 2));
    b = b_sh[7:0];
    h = h_sh[15:0];
    w = w_sh[31:0];
    load_align = '0;
    if (op[0])      load_align = DATA_W'(b);
    else if (op[1]) load_align = DATA_W'(h);
    else if (op[2]) load_align = DATA_W'(w);
    else if (op[3]) load_align = DATA_W'(b_sh[7:0]);
    else if (op[4]) load_align = DATA_W'(h_sh[15:0]);
    else if (op[5]) load_align = (DATA_W == 64) ? word : '0;
    else if (op[6]) load_align = (DATA_W == 64) ? DATA_W'(w_sh[31:0]) : '0;
  endfunction

  logic              r_vld_p1, r_need_resp_p1, r_buf_valid;
  logic [CNT_W-1:0]  r_discard_cnt;
  logic              r_ex_p1, r_res_from_mem_p1, r_gr_we_p1;
  logic [6:0]        r_load_op_p1;
  logic [4:0]        r_dest_p1;
  logic [DATA_W-1:0] r_alu_result_p1, r_rdata_buf;
  logic [31:0]       r_pc_p1;
  logic [SB_W-1:0]   r_sb_p1;

  logic              w_dok_drop, w_rsp_hit, w_ready_go, w_allowin, w_capture, w_leave;
  logic              w_store_buf, w_flush_lost, w_flush_ex, w_ms_ex;
  logic [CNT_W:0]    w_cnt_nxt;
  logic [DATA_W-1:0] w_load_word, w_load_data, w_final_result;

  assign w_dok_drop  = ms.data_sram_data_ok & (r_discard_cnt != '0);
  assign w_rsp_hit   = ms.data_sram_data_ok & (r_discard_cnt == '0) & r_vld_p1 &
                       r_need_resp_p1 & ~r_buf_valid;
  assign w_ready_go  = ~r_need_resp_p1 | r_buf_valid | w_rsp_hit;
  assign w_allowin   = ~r_vld_p1 | (w_ready_go & ms.ws_allowin);
  assign w_capture   = w_allowin & ms.es_to_ms_valid & ~ms.ms_flush_pipe;
  assign w_leave     = r_vld_p1 & w_ready_go & ms.ws_allowin;
  assign w_store_buf = w_rsp_hit & ~(ms.ws_allowin & ~ms.ms_flush_pipe);

  // A flush orphans the waiting load's response and any request EX already issued.
  assign w_flush_lost = r_vld_p1 & r_need_resp_p1 & ~r_buf_valid & ~w_rsp_hit;
  assign w_flush_ex   = ms.es_to_ms_valid & ms.es_req_sent;

  always_comb begin
    w_cnt_nxt = {1'b0, r_discard_cnt};
    if (ms.ms_flush_pipe)
      w_cnt_nxt = w_cnt_nxt + (CNT_W+1)'(w_flush_lost) + (CNT_W+1)'(w_flush_ex);
    if (w_dok_drop)
      w_cnt_nxt = w_cnt_nxt - (CNT_W+1)'(1);
  end

  // EX -> MEM boundary: control state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1      <= 1'b0;
      r_buf_valid   <= 1'b0;
      r_discard_cnt <= '0;
    end else begin
      r_discard_cnt <= w_cnt_nxt[CNT_W-1:0];
      if (ms.ms_flush_pipe) begin
        r_vld_p1    <= 1'b0;
        r_buf_valid <= 1'b0;
      end else begin
        if (w_allowin)
          r_vld_p1 <= ms.es_to_ms_valid;
        if (w_leave)
          r_buf_valid <= 1'b0;
        else if (w_store_buf)
          r_buf_valid <= 1'b1;
      end
    end
  end

  // EX -> MEM boundary: payload
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_need_resp_p1    <= ms.es_req_sent & ~ms.es_ex;
      r_ex_p1           <= ms.es_ex;
      r_load_op_p1      <= ms.es_load_op;
      r_res_from_mem_p1 <= ms.es_res_from_mem;
      r_gr_we_p1        <= ms.es_gr_we;
      r_dest_p1         <= ms.es_dest;
      r_alu_result_p1   <= ms.es_alu_result;
      r_pc_p1           <= ms.es_pc;
      r_sb_p1           <= ms.es_sb;
    end
    if (w_store_buf)
      r_rdata_buf <= ms.data_sram_rdata;
  end

  assert property (@(posedge clk) disable iff (reset) w_cnt_nxt <= (CNT_W+1)'(MAX_OUT))
    else $error("discard counter exceeds MAX_OUT");

  // MEM -> WB/ID boundary
  assign w_load_word    = r_buf_valid ? r_rdata_buf : ms.data_sram_rdata;
  assign w_load_data    = load_align(r_load_op_p1, w_load_word, r_alu_result_p1[OFF_W-1:0]);
  assign w_final_result = r_res_from_mem_p1 ? w_load_data : r_alu_result_p1;
  assign w_ms_ex        = r_ex_p1 & r_vld_p1;

  assign ms.ms_allowin     = w_allowin;
  assign ms.ms_to_ws_valid = r_vld_p1 & w_ready_go & ~ms.ms_flush_pipe;
  assign ms.ms_ex          = w_ms_ex;
  assign ms.ms_to_ws_bus   = {w_ms_ex, r_sb_p1, r_gr_we_p1, r_dest_p1, w_final_result, r_pc_p1};
  assign ms.ms_fwd_bus     = {r_sb_p1[0] & r_vld_p1,
                              r_vld_p1 & r_gr_we_p1 & ~w_ready_go,
                              r_vld_p1 & r_gr_we_p1 & w_ready_go,
                              r_dest_p1, w_final_result};
endmodule

// File: tb/tb_mem_stage_rsp.sv
// Directed bench for mem_stage_rsp: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_mem_stage_rsp;
  localparam logic [6:0] OP_LB  = 7'b0000001;
  localparam logic [6:0] OP_LH  = 7'b0000010;
  localparam logic [6:0] OP_LW  = 7'b0000100;
  localparam logic [6:0] OP_LBU = 7'b0001000;
  localparam logic [6:0] OP_LHU = 7'b0010000;
  localparam logic [6:0] OP_LD  = 7'b0100000;
  localparam logic [6:0] OP_LWU = 7'b1000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin, es_to_ms_valid, es_req_sent, es_ex, es_res_from_mem, es_gr_we;
  logic [6:0]  es_load_op;
  logic [4:0]  es_dest;
  logic [63:0] es_alu_result, es_sb, rdata;
  logic [31:0] es_pc;
  logic        data_ok, flush;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_stage_rsp_if #(.DATA_W(32), .SB_W(64)) if32 ();
  mem_stage_rsp_if #(.DATA_W(64), .SB_W(64)) if64 ();

  assign if32.ws_allowin        = ws_allowin;
  assign if32.es_to_ms_valid    = es_to_ms_valid;
  assign if32.es_req_sent       = es_req_sent;
  assign if32.es_ex             = es_ex;
  assign if32.es_load_op        = es_load_op;
  assign if32.es_res_from_mem   = es_res_from_mem;
  assign if32.es_gr_we          = es_gr_we;
  assign if32.es_dest           = es_dest;
  assign if32.es_alu_result     = es_alu_result[31:0];
  assign if32.es_pc             = es_pc;
  assign if32.es_sb             = es_sb;
  assign if32.data_sram_data_ok = data_ok;
  assign if32.data_sram_rdata   = rdata[31:0];
  assign if32.ms_flush_pipe     = flush;

  assign if64.ws_allowin        = ws_allowin;
  assign if64.es_to_ms_valid    = es_to_ms_valid;
  assign if64.es_req_sent       = es_req_sent;
  assign if64.es_ex             = es_ex;
  assign if64.es_load_op        = es_load_op;
  assign if64.es_res_from_mem   = es_res_from_mem;
  assign if64.es_gr_we          = es_gr_we;
  assign if64.es_dest           = es_dest;
  assign if64.es_alu_result     = es_alu_result;
  assign if64.es_pc             = es_pc;
  assign if64.es_sb             = es_sb;
  assign if64.data_sram_data_ok = data_ok;
  assign if64.data_sram_rdata   = rdata;
  assign if64.ms_flush_pipe     = flush;

  mem_stage_rsp #(.DATA_W(32), .SB_W(64), .MAX_OUT(2)) dut32 (.clk(clk), .reset(reset), .ms(if32));
  mem_stage_rsp #(.DATA_W(64), .SB_W(64), .MAX_OUT(2)) dut64 (.clk(clk), .reset(reset), .ms(if64));

  // Bus fields: {ex, sb, gr_we, dest, result, pc} and {csr_re, pending, valid, dest, result}
  logic [31:0] res32, pc32;
  logic [63:0] res64, sb32;
  logic        ex32, pend32, fv32, csr32, pend64, fv64;
  logic [4:0]  dest32;
  assign pc32   = if32.ms_to_ws_bus[31:0];
  assign res32  = if32.ms_to_ws_bus[63:32];
  assign dest32 = if32.ms_to_ws_bus[68:64];
  assign sb32   = if32.ms_to_ws_bus[133:70];
  assign ex32   = if32.ms_to_ws_bus[134];
  assign fv32   = if32.ms_fwd_bus[37];
  assign pend32 = if32.ms_fwd_bus[38];
  assign csr32  = if32.ms_fwd_bus[39];
  assign res64  = if64.ms_to_ws_bus[95:32];
  assign fv64   = if64.ms_fwd_bus[69];
  assign pend64 = if64.ms_fwd_bus[70];

  typedef struct {
    logic [6:0]  op;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [31:0] exp32;
    logic [63:0] exp64;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic issue(input logic [6:0] op, input logic [63:0] addr, input logic req,
                       input logic ex, input logic rfm, input logic [63:0] sb);
    es_to_ms_valid  = 1'b1;
    es_load_op      = op;
    es_alu_result   = addr;
    es_req_sent     = req;
    es_ex           = ex;
    es_res_from_mem = rfm;
    es_gr_we        = 1'b1;
    es_dest         = 5'd7;
    es_pc           = 32'h8000_0000 ^ addr[31:0];
    es_sb           = sb;
    tick;
    es_to_ms_valid  = 1'b0;
    es_req_sent     = 1'b0;
    es_ex           = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_LB,  64'h1003, 64'h0000_0000_80FF_0000, 32'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{OP_LBU, 64'h1001, 64'h0000_0000_0000_F100, 32'h0000_00F1, 64'h0000_0000_0000_00F1};
    vecs[2]  = '{OP_LH,  64'h1002, 64'h0000_0000_8001_0000, 32'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001};
    vecs[3]  = '{OP_LW,  64'h1000, 64'h0000_0000_1234_5678, 32'h1234_5678, 64'h0000_0000_1234_5678};
    vecs[4]  = '{OP_LD,  64'h1008, 64'h8000_0000_0000_0001, 32'h0000_0000, 64'h8000_0000_0000_0001};
    vecs[5]  = '{OP_LW,  64'h1004, 64'h8000_0000_0000_0005, 32'h0000_0005, 64'hFFFF_FFFF_8000_0000};
    vecs[6]  = '{OP_LWU, 64'h1004, 64'h8000_0000_0000_0005, 32'h0000_0000, 64'h0000_0000_8000_0000};
    vecs[7]  = '{OP_LB,  64'h1006, 64'h0011_2233_4455_6677, 32'h0000_0055, 64'h0000_0000_0000_0011};
    vecs[8]  = '{OP_LHU, 64'h1006, 64'hF00D_0000_C0DE_0000, 32'h0000_C0DE, 64'h0000_0000_0000_F00D};
    vecs[9]  = '{OP_LH,  64'h1006, 64'hF00D_0000_C0DE_0000, 32'hFFFF_C0DE, 64'hFFFF_FFFF_FFFF_F00D};
    vecs[10] = '{OP_LB,  64'h1007, 64'hFE00_0000_0000_0000, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFE};

    ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_req_sent = 1'b0; es_ex = 1'b0;
    es_res_from_mem = 1'b0; es_gr_we = 1'b0; es_load_op = '0; es_dest = '0;
    es_alu_result = '0; es_pc = '0; es_sb = '0; data_ok = 1'b0; rdata = '0; flush = 1'b0;

    reset = 1'b1;
    tick; tick; settle;
    chk("reset ms_to_ws_valid", if32.ms_to_ws_valid, 0);
    chk("reset ms_ex", if32.ms_ex, 0);
    chk("reset ms_allowin", if32.ms_allowin, 1);
    chk("reset fwd_pending", pend32, 0);
    chk("reset fwd_valid", fv32, 0);
    chk("reset64 ms_allowin", if64.ms_allowin, 1);
    reset = 1'b0;
    tick;

    // lb, response after three waiting cycles, passed straight through
    issue(OP_LB, 64'h1003, 1'b1, 1'b0, 1'b1, 64'h0);
    for (int i = 0; i < 3; i++) begin
      settle;
      chk($sformatf("t1 pending c%0d", i), pend32, 1);
      chk($sformatf("t1 wb_valid c%0d", i), if32.ms_to_ws_valid, 0);
      chk($sformatf("t1 allowin c%0d", i), if32.ms_allowin, 0);
      tick;
    end
    data_ok = 1'b1; rdata = 64'h0000_0000_80FF_0000;
    settle;
    chk("t1 wb_valid", if32.ms_to_ws_valid, 1);
    chk("t1 result32", res32, 32'hFFFF_FF80);
    chk("t1 result64", res64, 64'hFFFF_FFFF_FFFF_FF80);
    chk("t1 fwd_valid", fv32, 1);
    chk("t1 fwd_pending", pend32, 0);
    tick;
    data_ok = 1'b0; rdata = '0;
    settle;
    chk("t1 drained", if32.ms_to_ws_valid, 0);

    // lhu, response arrives while WB stalls and is held in the buffer
    issue(OP_LHU, 64'h2002, 1'b1, 1'b0, 1'b1, 64'h0);
    settle;
    chk("t2 pending", pend32, 1);
    ws_allowin = 1'b0; data_ok = 1'b1; rdata = 64'h0000_0000_BEEF_1234;
    settle;
    chk("t2 hit wb_valid", if32.ms_to_ws_valid, 1);
    chk("t2 hit allowin", if32.ms_allowin, 0);
    chk("t2 hit result", res32, 32'h0000_BEEF);
    tick;
    data_ok = 1'b0; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    settle;
    chk("t2 buf allowin", if32.ms_allowin, 0);
    chk("t2 buf wb_valid", if32.ms_to_ws_valid, 1);
    chk("t2 buf result32", res32, 32'h0000_BEEF);
    chk("t2 buf result64", res64, 64'h0000_0000_0000_BEEF);
    chk("t2 buf fwd_pending", pend32, 0);
    tick; settle;
    chk("t2 buf2 allowin", if32.ms_allowin, 0);
    chk("t2 buf2 result", res32, 32'h0000_BEEF);
    ws_allowin = 1'b1;
    settle;
    chk("t2 release allowin", if32.ms_allowin, 1);
    chk("t2 release result", res32, 32'h0000_BEEF);
    tick;
    rdata = '0;
    settle;
    chk("t2 drained", if32.ms_to_ws_valid, 0);

    // flush with a waiting load and a load leaving EX: two responses owed
    issue(OP_LW, 64'h3000, 1'b1, 1'b0, 1'b1, 64'h0);
    settle;
    chk("t3 pending", pend32, 1);
    es_to_ms_valid = 1'b1; es_req_sent = 1'b1; es_load_op = OP_LW; flush = 1'b1;
    settle;
    chk("t3 flush wb_valid", if32.ms_to_ws_valid, 0);
    tick;
    es_to_ms_valid = 1'b0; es_req_sent = 1'b0; flush = 1'b0;
    settle;
    chk("t3 after flush allowin", if32.ms_allowin, 1);
    chk("t3 after flush pending", pend32, 0);
    issue(OP_LW, 64'h3000, 1'b1, 1'b0, 1'b1, 64'h0);
    data_ok = 1'b1; rdata = 64'h0000_0000_DEAD_BEEF;
    settle;
    chk("t3 drop1 wb_valid", if32.ms_to_ws_valid, 0);
    chk("t3 drop1 pending", pend32, 1);
    tick;
    rdata = 64'h0000_0000_1111_1111;
    settle;
    chk("t3 drop2 wb_valid", if32.ms_to_ws_valid, 0);
    chk("t3 drop2 pending64", pend64, 1);
    tick;
    data_ok = 1'b0; rdata = '0;
    settle;
    chk("t3 gap pending", pend32, 1);
    tick;
    data_ok = 1'b1; rdata = 64'h0000_0000_0000_0042;
    settle;
    chk("t3 deliver wb_valid", if32.ms_to_ws_valid, 1);
    chk("t3 deliver result32", res32, 32'h0000_0042);
    chk("t3 deliver result64", res64, 64'h42);
    tick;
    data_ok = 1'b0; rdata = '0;
    settle;

    // flush in the same cycle as the waiting load's response: nothing owed
    issue(OP_LW, 64'h4000, 1'b1, 1'b0, 1'b1, 64'h0);
    data_ok = 1'b1; rdata = 64'h55; flush = 1'b1;
    settle;
    chk("t4 flush wb_valid", if32.ms_to_ws_valid, 0);
    tick;
    data_ok = 1'b0; flush = 1'b0; rdata = '0;
    settle;
    chk("t4 empty allowin", if32.ms_allowin, 1);
    issue(OP_LW, 64'h4000, 1'b1, 1'b0, 1'b1, 64'h0);
    data_ok = 1'b1; rdata = 64'h77;
    settle;
    chk("t4 next wb_valid", if32.ms_to_ws_valid, 1);
    chk("t4 next result", res32, 32'h77);
    tick;
    data_ok = 1'b0; rdata = '0;
    settle;

    // alignment and extension table, response in the first MEM cycle
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].addr, 1'b1, 1'b0, 1'b1, 64'h0);
      data_ok = 1'b1; rdata = vecs[i].rdata;
      settle;
      chk($sformatf("vec%0d wb_valid", i), if64.ms_to_ws_valid, 1);
      chk($sformatf("vec%0d result32", i), res32, vecs[i].exp32);
      chk($sformatf("vec%0d result64", i), res64, vecs[i].exp64);
      tick;
      data_ok = 1'b0; rdata = '0;
      settle;
    end

    // non-load carrying an exception: ready immediately
    issue(7'b0, 64'h1234, 1'b0, 1'b1, 1'b0, 64'h1);
    settle;
    chk("t6 wb_valid", if32.ms_to_ws_valid, 1);
    chk("t6 ms_ex", if32.ms_ex, 1);
    chk("t6 bus ex", ex32, 1);
    chk("t6 result32", res32, 32'h1234);
    chk("t6 result64", res64, 64'h1234);
    chk("t6 sb", sb32, 64'h1);
    chk("t6 pc", pc32, 32'h8000_1234);
    chk("t6 dest", dest32, 5'd7);
    chk("t6 csr_re", csr32, 1);
    chk("t6 fwd_valid", fv64, 1);
    chk("t6 fwd_pending", pend32, 0);
    tick; settle;
    chk("t6 left ms_ex", if32.ms_ex, 0);
    issue(OP_LW, 64'h1234, 1'b1, 1'b1, 1'b1, 64'h0);
    settle;
    chk("t6 ex load wb_valid", if32.ms_to_ws_valid, 1);
    chk("t6 ex load ms_ex", if32.ms_ex, 1);
    tick;
    issue(OP_LW, 64'h5000, 1'b1, 1'b0, 1'b1, 64'h0);
    data_ok = 1'b1; rdata = 64'h99;
    settle;
    chk("t6 follow wb_valid", if32.ms_to_ws_valid, 1);
    chk("t6 follow result", res32, 32'h99);
    tick;
    data_ok = 1'b0; rdata = '0;

    // reset while responses are owed and the buffer is full
    issue(OP_LW, 64'h6000, 1'b1, 1'b0, 1'b1, 64'h0);
    ws_allowin = 1'b0; data_ok = 1'b1; rdata = 64'h66;
    tick;
    data_ok = 1'b0; ws_allowin = 1'b1;
    issue(OP_LW, 64'h6000, 1'b1, 1'b0, 1'b1, 64'h0);
    es_to_ms_valid = 1'b1; es_req_sent = 1'b1; flush = 1'b1;
    tick;
    es_to_ms_valid = 1'b0; es_req_sent = 1'b0; flush = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    settle;
    chk("rst mid allowin", if32.ms_allowin, 1);
    chk("rst mid wb_valid", if32.ms_to_ws_valid, 0);
    issue(OP_LW, 64'h7000, 1'b1, 1'b0, 1'b1, 64'h0);
    settle;
    chk("rst mid buf cleared", pend32, 1);
    data_ok = 1'b1; rdata = 64'hAB;
    settle;
    chk("rst mid cnt cleared", if32.ms_to_ws_valid, 1);
    chk("rst mid result", res32, 32'hAB);
    tick;
    data_ok = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
